fpu_fsgnjn: RTL and testbench
=============================

# fpu_fsgnjn

Registered sign-injection unit for the single-precision FPU datapath. It implements RISC-V FSGNJN.S as its primary operation, with FSGNJ.S and FSGNJX.S selectable through `op`. Inputs arrive through a valid/ready handshake and results leave through a 2-entry output buffer. The block sits between the FPU operand-read stage and the FPU writeback arbiter.

## Interface
- Clocking/reset: one clock; reset is asynchronous and active-high.
- No parameters; the data width is fixed at 32 bits (IEEE-754 binary32).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  unit can accept a request this cycle
- `x1`  in  32  magnitude source (binary32 bit pattern)
- `x2`  in  32  sign source (binary32 bit pattern)
- `op`  in  2  00 = FSGNJ, 01 = FSGNJN, 10 = FSGNJX, 11 = FSGNJN
- `out_valid`  out  1  result present at buffer head
- `out_ready`  in  1  consumer accepts the head result
- `y`  out  32  result bit pattern

## Operation
- All operations are pure bit manipulation: `y[30:0] = x1[30:0]` always.
- Sign bit by `op`:
  - FSGNJN (01, 11): `y[31] = ~x2[31]`
  - FSGNJ (00): `y[31] = x2[31]`
  - FSGNJX (10): `y[31] = x1[31] ^ x2[31]`
- No floating-point interpretation is applied:
  - ±0, subnormals, infinities and NaNs all pass through exactly.
  - NaN payloads are not canonicalized.
  - No exception flags are produced.
  - The sign of x2 is taken from bit 31 even when x2 is -0 or NaN. For example, x2 = 0x80000000 counts as negative, so FSGNJN yields a positive result.
- The result is computed combinationally from x1, x2 and op. It is captured into the buffer when `in_valid && in_ready`.
- Output buffer: 2-entry FIFO, with head/tail pointers and a 2-bit count (0..2).
  - Push when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - `in_ready = (count != 2)`. This depends on registered state only, never on `out_ready`.
  - When full, a request is not accepted even if a pop happens in the same cycle.
  - `out_valid = (count != 0)`.
  - `y` = head entry. `y` holds stable while `out_valid && !out_ready`.
- Ordering: results leave strictly in acceptance order.

## Timing
- Latency: a request accepted at rising edge N is visible on `out_valid`/`y` after edge N (cycle N+1), provided the buffer is empty at that point. Requests never bypass the buffer combinationally.
- Throughput: one result per cycle when `out_ready` is held high.
- Backpressure: with `out_ready` low, two requests are accepted. `in_ready` then drops until a pop occurs, and rises in the cycle after that pop.
- Reset (asynchronous, immediate):
  - count = 0, pointers = 0, `out_valid` = 0, `in_ready` = 1.
  - Buffer data registers reset to 0, so `y` = 0x00000000.
  - Reset mid-operation discards all buffered results.
  - The first accepted request after reset deassertion follows the normal 1-cycle latency.
- No combinational path from `out_ready` or `in_valid` to `in_ready`.

## Test plan
- FSGNJN basic: x1 = 0x3F800000 (1.0), x2 = 0x40000000 (2.0), op = 01 → y = 0xBF800000. Same x1 with x2 = 0xC0000000 → y = 0x3F800000. Each result appears one cycle after acceptance.
- Zero/NaN sign handling with op = 01:
  - x1 = 0x80000000, x2 = 0x00000000 → y = 0x80000000.
  - x1 = 0x00000000, x2 = 0x80000000 → y = 0x00000000.
  - x1 = 0x7FC00001, x2 = 0x7F800000 → y = 0xFFC00001 (payload preserved).
- Op coverage with x1 = 0xC0490FDB, x2 = 0x80000001:
  - op 00 → 0xC0490FDB
  - op 01 → 0x40490FDB
  - op 10 → 0x40490FDB
  - op 11 → 0x40490FDB
- Exhaustive sweep: all exponents 0..255 for both operands, both signs, mantissas 0, 1, 2, 0x380000, 0x400000, 0x5FFFFF, 0x7FFFFF plus random values. For every case y must equal `{~x2[31], x1[30:0]}` (op = 01) bit-exact.
- Backpressure and order: hold `out_ready` = 0, drive three back-to-back requests A, B, C.
  - A and B are accepted, then `in_ready` = 0 and C is held.
  - Raise `out_ready`: outputs are A, B, C in order, with no duplicates or drops.
- Reset mid-stream: with 2 buffered results, pulse `rst` between clock edges. `out_valid` falls to 0 immediately and `in_ready` = 1. The next request yields exactly one result.

Source files
------------

// File: rtl/fpu_fsgnjn.sv
// Purpose: binary32 sign injection (FSGNJ/FSGNJN/FSGNJX); result is buffered in a 2-entry output FIFO.
// Latency: a result appears one cycle after acceptance. It never bypasses the buffer combinationally.
// Backpressure: in_ready = buffer not full, from registered state only. Two results are held while out_ready is low.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake carrying x1 (magnitude source), x2 (sign source), op
//   op                  00 FSGNJ, 01 FSGNJN, 10 FSGNJX, 11 FSGNJN
//   out_valid/out_ready result handshake; y is the buffer head

module fpu_fsgnjn_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  // Two-entry circular buffer. Each pointer is a single bit that toggles.
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // A push and a pop in the same cycle leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

module fpu_fsgnjn (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);
  typedef struct packed {
    logic        sign;
    logic [30:0] mag;
  } fp32_t;

  fp32_t res;
  logic  full;
  logic  empty;
  logic  push;
  logic  pop;

  // Only bit 31 of x2 affects the result. This reduction keeps x2's
  // magnitude bits visibly consumed.
  logic  x2_mag_unused;
  assign x2_mag_unused = ^x2[30:0];

  // Pure bit manipulation. -0 and NaN operands keep their raw sign bit, and NaN payloads pass through unchanged.
  always_comb begin
    res.mag  = x1[30:0];
    res.sign = ~x2[31];
    case (op)
      2'b00:   res.sign = x2[31];
      2'b10:   res.sign = x1[31] ^ x2[31];
      default: res.sign = ~x2[31];
    endcase
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fpu_fsgnjn_fifo2 #(.W(32)) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (res),
    .pop_rdy  (pop),
    .pop_dat  (y),
    .full     (full),
    .empty    (empty)
  );
endmodule

// File: tb/tb_fpu_fsgnjn.sv
module tb_fpu_fsgnjn;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int n_cmp = 0;
  int n_bad = 0;

  fpu_fsgnjn dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [1:0]  op;
    logic [31:0] y;
  } vec_t;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [1:0]  op;
  } stim_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the magnitude is copied from a. The sign is computed arithmetically from the two sign bits.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    int sa;
    int sb;
    int s;
    logic [31:0] mag;
    sa  = int'(a >> 31);
    sb  = int'(b >> 31);
    mag = a % 32'h8000_0000;
    if (o == 2'd0)      s = sb;
    else if (o == 2'd2) s = (sa + sb) % 2;
    else                s = 1 - sb;
    return mag + (s != 0 ? 32'h8000_0000 : 32'h0);
  endfunction

  // One isolated request with out_ready high. The result must be present at the next half-cycle.
  task automatic send_one(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] o, input logic [31:0] exp);
    @(negedge clk);
    x1 = a; x2 = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
    chk({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({name, " out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, " y"}, y, exp);
    @(posedge clk);
  endtask

  vec_t        tbl[9];
  stim_t       stim[$];
  logic [31:0] mq[$];
  logic [22:0] mants[7];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x1 = '0; x2 = '0; op = 2'b01;

    tbl[0] = '{32'h3F800000, 32'h40000000, 2'b01, 32'hBF800000};
    tbl[1] = '{32'h3F800000, 32'hC0000000, 2'b01, 32'h3F800000};
    tbl[2] = '{32'h80000000, 32'h00000000, 2'b01, 32'h80000000};
    tbl[3] = '{32'h00000000, 32'h80000000, 2'b01, 32'h00000000};
    tbl[4] = '{32'h7FC00001, 32'h7F800000, 2'b01, 32'hFFC00001};
    tbl[5] = '{32'hC0490FDB, 32'h80000001, 2'b00, 32'hC0490FDB};
    tbl[6] = '{32'hC0490FDB, 32'h80000001, 2'b01, 32'h40490FDB};
    tbl[7] = '{32'hC0490FDB, 32'h80000001, 2'b10, 32'h40490FDB};
    tbl[8] = '{32'hC0490FDB, 32'h80000001, 2'b11, 32'h40490FDB};

    mants[0] = 23'h0;      mants[1] = 23'h1;      mants[2] = 23'h2;
    mants[3] = 23'h380000; mants[4] = 23'h400000; mants[5] = 23'h5FFFFF;
    mants[6] = 23'h7FFFFF;

    // Reset state is checked while reset is still asserted.
    #12;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset y",         y,                  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    foreach (tbl[i]) send_one($sformatf("vec%0d", i), tbl[i].x1, tbl[i].x2, tbl[i].op, tbl[i].y);

    // Backpressure and ordering: A, B, C with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    x1 = 32'h11111111; x2 = 32'h00000000; op = 2'b01; in_valid = 1'b1;          // A
    @(negedge clk);
    chk("bp A accepted", {31'b0, out_valid}, 32'd1);
    chk("bp in_ready after A", {31'b0, in_ready}, 32'd1);
    x1 = 32'h22222222; x2 = 32'h80000000;                                       // B
    @(negedge clk);
    chk("bp in_ready full", {31'b0, in_ready}, 32'd0);
    chk("bp head A", y, 32'h91111111);
    x1 = 32'h33333333; x2 = 32'h00000000;                                       // C
    @(negedge clk);
    chk("bp C held", {31'b0, in_ready}, 32'd0);
    chk("bp head A stable", y, 32'h91111111);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp head B", y, 32'h22222222);
    chk("bp in_ready after pop", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp head C", y, 32'hB3333333);
    chk("bp C valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    chk("bp drained", {31'b0, out_valid}, 32'd0);

    // Reset mid-stream with two buffered results
    out_ready = 1'b0;
    x1 = 32'h40400000; x2 = 32'h0; op = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    x1 = 32'h40800000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst pre full", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst y",         y,                  32'h0);
    #1 rst = 1'b0;
    send_one("post-rst", 32'h40A00000, 32'h00000000, 2'b01, 32'hC0A00000);
    @(negedge clk);
    chk("post-rst single result", {31'b0, out_valid}, 32'd0);

    // Sweep: every exponent, both signs, edge mantissas (op 01), then random ops and values
    for (int k = 0; k < 3584; k++) begin
      stim_t s;
      int j;
      j = (k * 37 + 11) % 3584;
      s.x1 = {k[0], k[8+3:1+3] ^ 8'h0, mants[(k >> 1) % 7]};
      s.x1[30:23] = 8'((k >> 1) / 7);
      s.x2 = {j[0], 8'((j >> 1) / 7), mants[(j >> 1) % 7]};
      s.op = 2'b01;
      stim.push_back(s);
    end
    for (int k = 0; k < 600; k++) begin
      stim_t s;
      s.x1 = $urandom; s.x2 = $urandom;
      s.op = (k < 300) ? 2'b01 : 2'($urandom_range(0, 3));
      stim.push_back(s);
    end

    begin
      int  idx;
      int  cyc;
      bit  pending;
      idx = 0; cyc = 0; pending = 1'b0;
      while ((idx < stim.size() || mq.size() != 0) && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        chk("sweep out_valid", {31'b0, out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
        chk("sweep in_ready",  {31'b0, in_ready},  (mq.size() < 2) ? 32'd1 : 32'd0);
        if (!pending) begin
          if (idx < stim.size() && $urandom_range(0, 3) != 0) begin
            x1 = stim[idx].x1; x2 = stim[idx].x2; op = stim[idx].op;
            in_valid = 1'b1; pending = 1'b1;
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          chk("sweep y", y, mq[0]);
          void'(mq.pop_front());
        end
        if (in_valid && in_ready) begin
          mq.push_back(ref_model(x1, x2, op));
          idx++;
          pending = 1'b0;
        end
      end
      if (cyc >= 40000) begin
        n_cmp++; n_bad++;
        $display("FAIL sweep timeout: %0d requests issued, %0d results outstanding", idx, mq.size());
      end
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
